// File: rtl/select_block_rr_multi.sv
// Multi-grant round-robin select-tree node for the issue queue.
// Optional starvation promotion is enabled by defining SELECT_STARVE_GUARD_EN.
module select_block_rr_multi #(
    parameter int NUM_REQ      = 16,
    parameter int NUM_GRANT    = 2,
    parameter int STARVE_LIMIT = 15,
    localparam int PTR_W = $clog2(NUM_REQ),
    localparam int CNT_W = $clog2(NUM_GRANT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_GRANT-1:0] grant_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 req_o,
    output logic [CNT_W-1:0]     req_cnt_o,
    output logic [PTR_W-1:0]     ptr_o
);
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_nxt;
    logic                 ptr_adv;
    logic                 promo_vld;
    logic [PTR_W-1:0]     promo_idx;
    logic [NUM_GRANT-1:0] promo_sel;
    logic [PTR_W-1:0]     rr_idx [NUM_GRANT];
    logic [NUM_GRANT-1:0] rr_vld;
    logic [PTR_W-1:0]     slot_idx [NUM_GRANT];
    logic [NUM_GRANT-1:0] slot_vld;
    logic [NUM_GRANT-1:0] slot_rr;

    assign req_o = |req_i;
    assign ptr_o = ptr;

    always_comb begin
        int n;
        n = 0;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_i[i] && n < NUM_GRANT) n++;
        req_cnt_o = CNT_W'(n);
    end

    // Round-robin scan from ptr; the promoted index is left to its own slot.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        int               n;
        n      = 0;
        sum    = '0;
        idx    = '0;
        rr_vld = '0;
        for (int k = 0; k < NUM_GRANT; k++) rr_idx[k] = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(j);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (req_i[idx] && !(promo_vld && idx == promo_idx)) begin
                for (int k = 0; k < NUM_GRANT; k++) begin
                    if (n == k) begin
                        rr_idx[k] = idx;
                        rr_vld[k] = 1'b1;
                    end
                end
                n++;
            end
        end
    end

    // Slots after the promoted one shift the RR picks down by one.
    always_comb begin
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < NUM_GRANT; k++) begin
            slot_idx[k] = rr_idx[k];
            slot_vld[k] = rr_vld[k];
            slot_rr[k]  = 1'b1;
            if (promo_sel[k]) begin
                slot_idx[k] = promo_idx;
                slot_vld[k] = 1'b1;
                slot_rr[k]  = 1'b0;
                seen        = 1'b1;
            end else if (seen) begin
                slot_idx[k] = rr_idx[(k > 0) ? k - 1 : 0];
                slot_vld[k] = rr_vld[(k > 0) ? k - 1 : 0];
            end
        end
    end

    always_comb begin
        logic [PTR_W-1:0] last;
        last    = '0;
        ptr_adv = 1'b0;
        grant_o = '0;
        for (int k = 0; k < NUM_GRANT; k++) begin
            if (slot_vld[k] && grant_i[k]) begin
                grant_o[slot_idx[k]] = 1'b1;
                if (slot_rr[k]) begin
                    ptr_adv = 1'b1;
                    last    = slot_idx[k];
                end
            end
        end
        if (reset) grant_o = '0;
        ptr_nxt = (last == PTR_W'(NUM_REQ - 1)) ? '0 : last + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ptr <= '0;
        else if (ptr_adv) ptr <= ptr_nxt;
    end

`ifdef SELECT_STARVE_GUARD_EN
    localparam int            SW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve [NUM_REQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) starve[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_i[i] || grant_o[i]) starve[i] <= '0;
                else if (starve[i] != LIM)   starve[i] <= starve[i] + SW'(1);
            end
        end
    end

    // Lowest saturated index wins; it takes the lowest enabled slot.
    always_comb begin
        promo_vld = 1'b0;
        promo_idx = '0;
        promo_sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (starve[i] == LIM) begin
                promo_vld = 1'b1;
                promo_idx = PTR_W'(i);
            end
        end
        if (promo_vld) begin
            if (grant_i == '0) begin
                promo_sel[0] = 1'b1;
            end else begin
                for (int k = NUM_GRANT - 1; k >= 0; k--) begin
                    if (grant_i[k]) begin
                        promo_sel    = '0;
                        promo_sel[k] = 1'b1;
                    end
                end
            end
        end
    end
`else
    assign promo_vld = 1'b0;
    assign promo_idx = '0;
    assign promo_sel = '0;
`endif

endmodule
